// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, operation
// encoding, interrupt codes and the bit positions of the WARL fields.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MENVCFG       = 12'h30A;
  localparam logic [11:0] CSR_MSTATUSH      = 12'h310;
  localparam logic [11:0] CSR_MENVCFGH      = 12'h31A;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;
  localparam logic [11:0] CSR_MCONFIGPTR    = 12'hF15;

  localparam logic [30:0] IRQ_SOFTWARE = 31'd3;
  localparam logic [30:0] IRQ_TIMER    = 31'd7;
  localparam logic [30:0] IRQ_EXTERNAL = 31'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MSIE     = 3;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

  // Packs {external, timer, software} into the mie/mip bit layout.
  function automatic logic [31:0] irq_bits(input logic [2:0] b);
    logic [31:0] r;
    r           = '0;
    r[MIE_MEIE] = b[2];
    r[MIE_MTIE] = b[1];
    r[MIE_MSIE] = b[0];
    return r;
  endfunction

  function automatic logic [31:0] inhibit_mask(input int num_hpm);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int i = 0; i < num_hpm; i++) m[3+i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access port between the core pipeline (master) and the CSR file (slave).
interface csr_if;
  import csr_pkg::*;

  // No handshake: an op other than CSR_NONE is always accepted and commits at
  // the next rising edge; read_value/illegal are combinational on the address.
  logic [11:0] csr_address;
  csr_op_e     csr_op;
  logic [31:0] csr_write_value;
  logic [31:0] csr_read_value;
  logic        csr_illegal;

  modport master (
    output csr_address, csr_op, csr_write_value,
    input  csr_read_value, csr_illegal
  );

  modport slave (
    input  csr_address, csr_op, csr_write_value,
    output csr_read_value, csr_illegal
  );
endinterface

// File: rtl/csr_counter.sv
// Free-running event counter with split 32-bit write access; a write in the
// same cycle takes precedence over the increment.
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             increment,
  input  logic             inhibit,
  input  logic             write_lo,
  input  logic             write_hi,
  input  logic [31:0]      write_value,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value <= '0;
    end else if (write_lo) begin
      value[31:0] <= write_value;
    end else if (write_hi) begin
      value[WIDTH-1:32] <= write_value[WIDTH-33:0];
    end else if (increment && !inhibit) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSR read/modify/write, counters, trap entry and mret.
module csr_file
  import csr_pkg::*;
#(
  parameter int          COUNTER_WIDTH = 64,
  parameter int          NUM_HPM       = 0,
  parameter logic [31:0] HART_ID       = 32'h0,
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter bit          VECTORED_EN   = 1'b1
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  csr_if.slave                                  csr,
  input  logic                                  instret,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
  input  logic                                  irq_external,
  input  logic                                  irq_timer,
  input  logic                                  irq_software,
  input  logic                                  trap_valid,
  input  logic                                  trap_interrupt,
  input  logic [30:0]                           trap_cause,
  input  logic [31:0]                           trap_pc,
  input  logic [31:0]                           trap_value,
  input  logic                                  mret,
  output logic [31:0]                           trap_target,
  output logic [31:0]                           mepc_out,
  output logic                                  interrupt_pending
);

  localparam logic [31:0] INHIBIT_MASK = inhibit_mask(NUM_HPM);

  logic        st_mie, st_mpie;
  logic [29:0] mtvec_base;
  logic        mtvec_mode;
  logic [2:0]  mie_en, mip_q;
  logic [31:0] mscratch, mcause, mtval, mcountinhibit;
  logic [29:0] mepc;

  logic [31:0] read_value, new_value;
  logic        implemented, illegal, wr_en;
  logic        mie_next, pending_next;
  logic [2:0]  mie_en_next, irq_now;
  logic [4:0]  hpm_idx;

  logic [COUNTER_WIDTH-1:0] cycle_val, instret_val;
  logic [63:0]              cycle_ext, instret_ext;
  logic [63:0]              hpm_val [29];

  assign cycle_ext   = 64'(cycle_val);
  assign instret_ext = 64'(instret_val);
  assign irq_now     = {irq_external, irq_timer, irq_software};
  assign hpm_idx     = csr.csr_address[4:0] - 5'd3;

  always_comb begin
    read_value  = '0;
    implemented = 1'b1;
    case (csr.csr_address)
      CSR_MSTATUS:       read_value = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      CSR_MISA:          read_value = MISA_RV32I;
      CSR_MIE:           read_value = irq_bits(mie_en);
      CSR_MTVEC:         read_value = {mtvec_base, 1'b0, mtvec_mode};
      CSR_MHARTID:       read_value = HART_ID;
      CSR_MCOUNTINHIBIT: read_value = mcountinhibit;
      CSR_MSCRATCH:      read_value = mscratch;
      CSR_MEPC:          read_value = {mepc, 2'b00};
      CSR_MCAUSE:        read_value = mcause;
      CSR_MTVAL:         read_value = mtval;
      CSR_MIP:           read_value = irq_bits(mip_q);
      CSR_MCYCLE:        read_value = cycle_ext[31:0];
      CSR_MCYCLEH:       read_value = cycle_ext[63:32];
      CSR_MINSTRET:      read_value = instret_ext[31:0];
      CSR_MINSTRETH:     read_value = instret_ext[63:32];
      CSR_MENVCFG, CSR_MENVCFGH, CSR_MSTATUSH, CSR_MVENDORID,
      CSR_MARCHID, CSR_MIMPID, CSR_MCONFIGPTR: read_value = '0;
      default: begin
        // HPM counter/event windows: index 3..31 within each 32-entry block.
        if (csr.csr_address[4:0] < 5'd3) begin
          implemented = 1'b0;
        end else if (csr.csr_address[11:5] == CSR_MCYCLE[11:5]) begin
          read_value = hpm_val[hpm_idx][31:0];
        end else if (csr.csr_address[11:5] == CSR_MCYCLEH[11:5]) begin
          read_value = hpm_val[hpm_idx][63:32];
        end else if (csr.csr_address[11:5] != CSR_MCOUNTINHIBIT[11:5]) begin
          implemented = 1'b0;
        end
      end
    endcase
  end

  assign illegal = !implemented ||
                   (csr.csr_op != CSR_NONE && csr.csr_address[11:10] == 2'b11);
  assign csr.csr_read_value = read_value;
  assign csr.csr_illegal    = illegal;
  assign wr_en = (csr.csr_op != CSR_NONE) && !illegal && !trap_valid && !mret;

  always_comb begin
    case (csr.csr_op)
      CSR_WRITE: new_value = csr.csr_write_value;
      CSR_SET:   new_value = read_value | csr.csr_write_value;
      CSR_CLEAR: new_value = read_value & ~csr.csr_write_value;
      default:   new_value = read_value;
    endcase
  end

  // Next-state of the interrupt enables so the pending flag tracks the
  // registered state it is derived from without an extra cycle of lag.
  always_comb begin
    mie_next    = st_mie;
    mie_en_next = mie_en;
    if (trap_valid) begin
      mie_next = 1'b0;
    end else if (mret) begin
      mie_next = st_mpie;
    end else if (wr_en && csr.csr_address == CSR_MSTATUS) begin
      mie_next = new_value[MSTATUS_MIE];
    end
    if (wr_en && csr.csr_address == CSR_MIE) begin
      mie_en_next = {new_value[MIE_MEIE], new_value[MIE_MTIE], new_value[MIE_MSIE]};
    end
  end

  assign pending_next = mie_next & |(mie_en_next & irq_now);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st_mie            <= 1'b0;
      st_mpie           <= 1'b0;
      mtvec_base        <= RESET_VECTOR[31:2];
      mtvec_mode        <= 1'b0;
      mie_en            <= '0;
      mip_q             <= '0;
      mscratch          <= '0;
      mepc              <= '0;
      mcause            <= '0;
      mtval             <= '0;
      mcountinhibit     <= '0;
      interrupt_pending <= 1'b0;
    end else begin
      mip_q             <= irq_now;
      interrupt_pending <= pending_next;
      st_mie            <= mie_next;
      mie_en            <= mie_en_next;
      if (trap_valid) begin
        st_mpie <= st_mie;
        mepc    <= trap_pc[31:2];
        mcause  <= {trap_interrupt, trap_cause};
        mtval   <= trap_value;
      end else if (mret) begin
        st_mpie <= 1'b1;
      end else if (wr_en) begin
        case (csr.csr_address)
          CSR_MSTATUS:       st_mpie <= new_value[MSTATUS_MPIE];
          CSR_MTVEC: begin
            mtvec_base <= new_value[31:2];
            if (new_value[1:0] == 2'b00) mtvec_mode <= 1'b0;
            else if (new_value[1:0] == 2'b01 && VECTORED_EN) mtvec_mode <= 1'b1;
          end
          CSR_MSCRATCH:      mscratch      <= new_value;
          CSR_MEPC:          mepc          <= new_value[31:2];
          CSR_MCAUSE:        mcause        <= new_value;
          CSR_MTVAL:         mtval         <= new_value;
          CSR_MCOUNTINHIBIT: mcountinhibit <= new_value & INHIBIT_MASK;
          default: ;
        endcase
      end
    end
  end

  assign trap_target = {mtvec_base, 2'b00} +
                       ((mtvec_mode && trap_interrupt) ? {trap_cause[29:0], 2'b00} : 32'h0);
  assign mepc_out    = {mepc, 2'b00};

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_mcycle (
    .clock, .reset_n,
    .increment   (1'b1),
    .inhibit     (mcountinhibit[0]),
    .write_lo    (wr_en && csr.csr_address == CSR_MCYCLE),
    .write_hi    (wr_en && csr.csr_address == CSR_MCYCLEH),
    .write_value (new_value),
    .value       (cycle_val)
  );

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_minstret (
    .clock, .reset_n,
    .increment   (instret),
    .inhibit     (mcountinhibit[2]),
    .write_lo    (wr_en && csr.csr_address == CSR_MINSTRET),
    .write_hi    (wr_en && csr.csr_address == CSR_MINSTRETH),
    .write_value (new_value),
    .value       (instret_val)
  );

  for (genvar i = 0; i < 29; i++) begin : g_hpm
    if (i < NUM_HPM) begin : g_impl
      logic [COUNTER_WIDTH-1:0] value;
      csr_counter #(.WIDTH(COUNTER_WIDTH)) u_hpm (
        .clock, .reset_n,
        .increment   (hpm_event[i]),
        .inhibit     (mcountinhibit[3+i]),
        .write_lo    (wr_en && csr.csr_address == CSR_MHPMCOUNTER3 + 12'(i)),
        .write_hi    (wr_en && csr.csr_address == CSR_MHPMCOUNTER3H + 12'(i)),
        .write_value (new_value),
        .value       (value)
      );
      assign hpm_val[i] = 64'(value);
    end else begin : g_none
      assign hpm_val[i] = '0;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset, RMW ops, WARL fields, counters, traps,
// mret, interrupt pending and reset/trap/write collisions.
module tb_csr_file;
  import csr_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        instret = 1'b0;
  logic [0:0]  hpm_event = 1'b0;
  logic        irq_external = 1'b0, irq_timer = 1'b0, irq_software = 1'b0;
  logic        trap_valid = 1'b0, trap_interrupt = 1'b0, mret = 1'b0;
  logic [30:0] trap_cause = '0;
  logic [31:0] trap_pc = '0, trap_value = '0;
  logic [31:0] trap_target, mepc_out;
  logic        interrupt_pending;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  csr_if bus ();

  csr_file #(
    .COUNTER_WIDTH (64),
    .NUM_HPM       (1),
    .HART_ID       (32'd5),
    .RESET_VECTOR  (32'h0000_0100),
    .VECTORED_EN   (1'b1)
  ) dut (
    .clock, .reset_n,
    .csr (bus),
    .instret, .hpm_event,
    .irq_external, .irq_timer, .irq_software,
    .trap_valid, .trap_interrupt, .trap_cause, .trap_pc, .trap_value,
    .mret, .trap_target, .mepc_out, .interrupt_pending
  );

  // clock/reset
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_address = a;
    bus.csr_op      = CSR_NONE;
    #1;
    check(tag, bus.csr_read_value, exp);
  endtask

  // Presents one CSR op at a falling edge; returns at the next falling edge.
  task automatic write_csr(input logic [11:0] a, input csr_op_e op, input logic [31:0] v);
    bus.csr_address     = a;
    bus.csr_op          = op;
    bus.csr_write_value = v;
    @(negedge clock);
    bus.csr_op = CSR_NONE;
  endtask

  initial begin
    bus.csr_address     = '0;
    bus.csr_op          = CSR_NONE;
    bus.csr_write_value = '0;

    // Reset for two rising edges
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check_csr("mcycle_reset", CSR_MCYCLE, 32'd0);
    check("pending_reset", {31'b0, interrupt_pending}, 32'd0);
    check_csr("mtvec_reset", CSR_MTVEC, 32'h0000_0100);
    check_csr("mhartid", CSR_MHARTID, 32'd5);
    check_csr("misa", CSR_MISA, 32'h4000_0100);
    check_csr("mstatus_reset", CSR_MSTATUS, 32'h0000_1800);
    @(negedge clock);
    check_csr("mcycle_first", CSR_MCYCLE, 32'd1);

    // WRITE / SET / CLEAR
    write_csr(CSR_MSCRATCH, CSR_WRITE, 32'hF0F0_0000);
    write_csr(CSR_MSCRATCH, CSR_SET,   32'h0000_000F);
    write_csr(CSR_MSCRATCH, CSR_CLEAR, 32'hF000_0000);
    check_csr("mscratch_rmw", CSR_MSCRATCH, 32'h00F0_000F);

    // Illegal accesses
    bus.csr_address = CSR_MVENDORID; bus.csr_op = CSR_WRITE; bus.csr_write_value = 32'h1234;
    #1 check("ro_write_illegal", {31'b0, bus.csr_illegal}, 32'd1);
    @(negedge clock);
    check_csr("mvendorid", CSR_MVENDORID, 32'd0);
    check("ro_read_legal", {31'b0, bus.csr_illegal}, 32'd0);
    check_csr("unimpl_read", 12'h7C0, 32'd0);
    check("unimpl_illegal", {31'b0, bus.csr_illegal}, 32'd1);
    check_csr("hpm4_unimpl", 12'hB04, 32'd0);
    check("hpm4_legal", {31'b0, bus.csr_illegal}, 32'd0);

    // WARL: reserved mtvec MODE keeps the old MODE; mie mask
    write_csr(CSR_MTVEC, CSR_WRITE, 32'h0000_2003);
    check_csr("mtvec_warl", CSR_MTVEC, 32'h0000_2000);

    // Counter wrap and write-over-increment
    write_csr(CSR_MCYCLE, CSR_WRITE, 32'hFFFF_FFFF);
    check_csr("mcycle_lo_written", CSR_MCYCLE, 32'hFFFF_FFFF);
    write_csr(CSR_MCYCLEH, CSR_WRITE, 32'hFFFF_FFFF);
    check_csr("mcycle_lo_kept", CSR_MCYCLE, 32'hFFFF_FFFF);
    check_csr("mcycleh_written", CSR_MCYCLEH, 32'hFFFF_FFFF);
    @(negedge clock);
    check_csr("mcycle_wrap", CSR_MCYCLE, 32'd0);
    check_csr("mcycleh_wrap", CSR_MCYCLEH, 32'd0);
    write_csr(CSR_MCOUNTINHIBIT, CSR_WRITE, 32'hFFFF_FFFF);
    check_csr("inhibit_mask", CSR_MCOUNTINHIBIT, 32'h0000_000D);
    @(negedge clock);
    @(negedge clock);
    check_csr("mcycle_frozen", CSR_MCYCLE, 32'd1);

    // minstret and mhpmcounter3 with only CY inhibited
    write_csr(CSR_MCOUNTINHIBIT, CSR_WRITE, 32'h0000_0001);
    hpm_event = 1'b1; instret = 1'b1;
    @(negedge clock);
    @(negedge clock);
    instret = 1'b0;
    @(negedge clock);
    hpm_event = 1'b0;
    write_csr(CSR_MCOUNTINHIBIT, CSR_WRITE, 32'h0000_0009);
    hpm_event = 1'b1;
    @(negedge clock);
    hpm_event = 1'b0;
    check_csr("hpm3", CSR_MHPMCOUNTER3, 32'd3);
    check_csr("hpm3h", CSR_MHPMCOUNTER3H, 32'd0);
    check_csr("minstret", CSR_MINSTRET, 32'd2);
    check_csr("mcycle_still", CSR_MCYCLE, 32'd1);
    check_csr("mhpmevent3", CSR_MHPMEVENT3, 32'd0);

    // Trap with a coinciding mstatus write (dropped)
    write_csr(CSR_MTVEC, CSR_WRITE, 32'h0000_1001);
    check_csr("mtvec_vectored", CSR_MTVEC, 32'h0000_1001);
    write_csr(CSR_MSTATUS, CSR_WRITE, 32'h0000_0008);
    check_csr("mstatus_mie_set", CSR_MSTATUS, 32'h0000_1808);
    trap_valid = 1'b1; trap_interrupt = 1'b0; trap_cause = IRQ_TIMER;
    trap_pc = 32'h0000_0202; trap_value = 32'hDEAD_BEEF;
    bus.csr_address = CSR_MSTATUS; bus.csr_op = CSR_WRITE; bus.csr_write_value = 32'h0000_0088;
    #1 check("target_exception", trap_target, 32'h0000_1000);
    trap_interrupt = 1'b1;
    #1 check("target_vectored", trap_target, 32'h0000_101C);
    @(negedge clock);
    trap_valid = 1'b0; trap_interrupt = 1'b0; bus.csr_op = CSR_NONE;
    check("mepc_out", mepc_out, 32'h0000_0200);
    check_csr("mepc", CSR_MEPC, 32'h0000_0200);
    check_csr("mcause", CSR_MCAUSE, 32'h8000_0007);
    check_csr("mtval", CSR_MTVAL, 32'hDEAD_BEEF);
    check_csr("mstatus_trap", CSR_MSTATUS, 32'h0000_1880);

    // mret, then a timer interrupt
    write_csr(CSR_MIE, CSR_WRITE, 32'hFFFF_FFFF);
    check_csr("mie_mask", CSR_MIE, 32'h0000_0888);
    mret = 1'b1;
    @(negedge clock);
    mret = 1'b0;
    check_csr("mstatus_mret", CSR_MSTATUS, 32'h0000_1888);
    check("pending_idle", {31'b0, interrupt_pending}, 32'd0);
    irq_timer = 1'b1;
    #1 check("pending_not_yet", {31'b0, interrupt_pending}, 32'd0);
    @(negedge clock);
    check("pending_set", {31'b0, interrupt_pending}, 32'd1);
    check_csr("mip_timer", CSR_MIP, 32'h0000_0080);
    write_csr(CSR_MEPC, CSR_WRITE, 32'h0000_0203);
    check_csr("mepc_align", CSR_MEPC, 32'h0000_0200);

    // Reset together with trap and CSR write
    reset_n = 1'b0; irq_timer = 1'b0;
    trap_valid = 1'b1; trap_interrupt = 1'b1; trap_cause = IRQ_SOFTWARE;
    trap_pc = 32'h0000_0400; trap_value = 32'h1111_2222;
    bus.csr_address = CSR_MSCRATCH; bus.csr_op = CSR_WRITE; bus.csr_write_value = 32'h0000_1234;
    @(negedge clock);
    reset_n = 1'b1; trap_valid = 1'b0; trap_interrupt = 1'b0; bus.csr_op = CSR_NONE;
    check_csr("mcycle_rst2", CSR_MCYCLE, 32'd0);
    check("pending_rst2", {31'b0, interrupt_pending}, 32'd0);
    check_csr("mepc_rst2", CSR_MEPC, 32'd0);
    check_csr("mcause_rst2", CSR_MCAUSE, 32'd0);
    check_csr("mstatus_rst2", CSR_MSTATUS, 32'h0000_1800);
    check_csr("mscratch_rst2", CSR_MSCRATCH, 32'd0);
    check_csr("mtvec_rst2", CSR_MTVEC, 32'h0000_0100);
    check_csr("mie_rst2", CSR_MIE, 32'd0);
    check_csr("inhibit_rst2", CSR_MCOUNTINHIBIT, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
Sequential machine-mode CSR file; successor to the combinational CSR read decoder.
- Holds all M-mode CSR state and executes CSR write/set/clear operations.
- Performs trap entry and mret state updates; drives the trap target and pending-interrupt signals to the core.
- Parametrised in counter width, number of HPM counters, reset vector and mtvec mode support.

Parameters:
COUNTER_WIDTH, 64, implemented bits of mcycle/minstret/mhpmcounterN (33..64); unimplemented upper bits read 0.
NUM_HPM, 0, implemented mhpmcounter3..(3+NUM_HPM-1) (0..29); the rest read 0 and ignore writes.
HART_ID, 0, value returned by mhartid.
RESET_VECTOR, 32'h0000_0000, mtvec reset value (bits[1:0] must be 0).
VECTORED_EN, 1, when 1 mtvec.MODE accepts 1 (vectored); when 0, MODE is read-only 0.

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clock
csr_address  input  12  CSR address
csr_op  input  2  0 NONE, 1 WRITE, 2 SET, 3 CLEAR
csr_write_value  input  32  operand for WRITE/SET/CLEAR
csr_read_value  output  32  combinational read of the addressed CSR (old value)
csr_illegal  output  1  combinational: address unimplemented, or op≠NONE to a read-only CSR
instret  input  1  one instruction retired this cycle
hpm_event  input  NUM_HPM (min 1)  per-counter increment pulses
irq_external / irq_timer / irq_software  input  1 each  level interrupt sources → mip.MEIP/MTIP/MSIP
trap_valid  input  1  take a trap this cycle
trap_interrupt  input  1  trap is an interrupt
trap_cause  input  31  exception or interrupt code
trap_pc  input  32  pc to save in mepc
trap_value  input  32  value to save in mtval
mret  input  1  execute mret this cycle
trap_target  output  32  combinational next pc for trap_valid
mepc_out  output  32  current mepc, for mret
interrupt_pending  output  1  registered: mstatus.MIE & |(mie & mip)

Behaviour:
Read path
- Read is combinational. csr_read_value always reflects pre-edge state.
- Read-only IDs (mvendorid, marchid, mimpid, mconfigptr, menvcfg/h, mstatush) return 0.
- misa returns RV32I. mhartid returns HART_ID. Unimplemented addresses read 0 with csr_illegal=1.

Write path
- A write commits at the rising edge. New value: WRITE=v, SET=old|v, CLEAR=old&~v.
- Write to address[11:10]==2'b11, or to an unimplemented address: csr_illegal=1, no state change.
- WARL fields:
  - mstatus: only MIE/MPIE writable; MPP reads 2'b11.
  - mtvec: MODE values other than 0/1 keep the old MODE.
  - mepc[1:0] always 0.
  - mie: only MEIE/MTIE/MSIE writable.
  - mip: read-only; bits are the registered irq inputs.

Counters (mcycle, minstret, mhpmcounterN)
- mcountinhibit (0x320) implements bits CY, IR and HPM3..; other bits read 0.
- mcycle increments every cycle unless CY is set.
- minstret increments when instret=1 unless IR is set.
- mhpmcounterN increments on hpm_event[N-3] unless its inhibit bit is set. mhpmeventN reads 0.
- A CSR write to either half of a counter in the same cycle wins over the increment.
  - Low-half write replaces bits[31:0] and keeps the upper bits; high-half write is the converse.
- Counters wrap from 2^COUNTER_WIDTH-1 to 0.

Traps and mret
- Priority: reset_n low > trap_valid > mret > CSR write. A CSR write coinciding with trap_valid or mret is dropped.
- Trap edge:
  - mepc←{trap_pc[31:2],2'b0}
  - mcause←{trap_interrupt,trap_cause}
  - mtval←trap_value
  - MPIE←MIE, MIE←0
- mret edge: MIE←MPIE, MPIE←1.
- trap_target = {base,2'b0}, plus 4*trap_cause when MODE=1 and trap_interrupt=1.

Reset (reset_n=0 at an edge)
- mstatus MIE=MPIE=0; mtvec=RESET_VECTOR with MODE 0.
- mie, mip, mscratch, mepc, mcause, mtval, mcountinhibit, all counters = 0.
- interrupt_pending=0.
- Reset mid-operation discards any trap, mret or write presented in that cycle.

Decomposition:
- csr_pkg: CSR address localparams, csr_op encoding, mcause interrupt codes (3,7,11), mstatus/mie bit indices.
- One sub-module, csr_counter (parameter WIDTH; ports increment, inhibit, write_lo, write_hi, write_value, value), instantiated for mcycle, minstret and each generated HPM counter.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, release → mtvec reads RESET_VECTOR; mcycle reads 0 then 1 on the next cycle; interrupt_pending=0.
- SET/CLEAR: WRITE mscratch=32'hF0F0_0000, SET 32'h0000_000F, CLEAR 32'hF000_0000 → reads 32'h00F0_000F; WRITE to mvendorid → csr_illegal=1, reads 0.
- Counter wrap: COUNTER_WIDTH=64; write mcycle=32'hFFFF_FFFF, mcycleh=32'hFFFF_FFFF → next cycle reads 0/0. Set mcountinhibit.CY → value frozen. Write in the same cycle as an increment → written value exactly.
- Trap: mtvec=32'h0000_1001, MIE=1, trap_valid with interrupt cause 7, trap_pc=32'h0000_0202 → trap_target=32'h0000_101C; mepc=32'h0000_0200; mcause=32'h8000_0007; MIE=0, MPIE=1.
- mret, then irq_timer=1 with mie.MTIE=1 → MIE restored to 1; interrupt_pending=1 one cycle after irq rises.
- Collision: CSR WRITE to mstatus together with trap_valid → write dropped, trap updates applied. reset_n=0 together with trap_valid → reset values only.
